// File: rtl/single_multiply_v_s.sv
// -----------------------------------------------------------------------------
// single_multiply_v_s
//
// Multiplies every IEEE-754 fp32 element of vector_a by the fp32 scalar b:
//   vector_c[i] = vector_a[i] * b
// A single two-stage fp32 multiplier is shared across all elements. It accepts
// one element per cycle, so a full vector takes WIDTH + 2 busy cycles.
//
// Ports
//   clk       in   rising-edge clock
//   rstn      in   synchronous active-low reset
//   start     in   one-cycle request; vector_a and b are sampled on the same edge
//   vector_a  in   [WIDTH] x 32-bit fp32 operand vector
//   b         in   32-bit fp32 scalar
//   busy      out  high while an operation is in flight
//   done      out  one-cycle pulse; vector_c is complete
//   vector_c  out  [WIDTH] x 32-bit fp32 results, held until the next accepted start
//
// Handshake: start is honoured only while busy=0. This includes the cycle in
// which done is high. Any start seen while busy=1 is dropped.
//
// Configuration macro: SINGLE_MULT_ROUND_EN
//   defined   -> round-to-nearest-even using the guard and sticky bits of the product
//   undefined -> truncate (round toward zero)
//
// Denormal inputs are treated as zero. Results that underflow are flushed to
// signed zero, and results that overflow saturate to signed infinity.
// -----------------------------------------------------------------------------
module single_multiply_v_s #(
    parameter int WIDTH = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [31:0] vector_a [WIDTH],
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] vector_c [WIDTH]
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]    state;
    logic [IW-1:0] index;
    logic [31:0]   a_q [WIDTH];
    logic [31:0]   b_q;
    logic          issue;

    // Pipeline registers
    logic                v1, v2;
    logic                last_s1, last_s2;
    logic [IW-1:0]       idx_s1;
    logic                sign_s1;
    logic signed [9:0]   exp_s1;
    logic                nan_s1, inf_s1, zero_s1;
`ifdef SINGLE_MULT_ROUND_EN
    logic [47:0]         prod_s1;
`else
    // Without rounding, bits below the 23-bit mantissa window are never used.
    logic [47:23]        prod_s1;
`endif

    assign issue = (state == ST_RUN);

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= ST_IDLE;
            index <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                        index <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (index == IW'(WIDTH - 1)) state <= ST_DRAIN;
                    else                         index <= index + 1'b1;
                end
                ST_DRAIN: begin
                    // The last element was written to vector_c on the previous edge.
                    if (v2 && last_s2) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Operands are captured once per operation. This isolates the running
    // operation from any later changes on the input ports.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && start) begin
            for (int i = 0; i < WIDTH; i++) a_q[i] <= vector_a[i];
            b_q <= b;
        end
    end

    // ---------------------------------------------------- stage 1: unpack
    logic [31:0] op_a;
    logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;

    assign op_a   = a_q[index];
    assign a_zero = (op_a[30:23] == 8'h00);
    assign a_inf  = (op_a[30:23] == 8'hFF) && (op_a[22:0] == 23'd0);
    assign a_nan  = (op_a[30:23] == 8'hFF) && (op_a[22:0] != 23'd0);
    assign b_zero = (b_q[30:23] == 8'h00);
    assign b_inf  = (b_q[30:23] == 8'hFF) && (b_q[22:0] == 23'd0);
    assign b_nan  = (b_q[30:23] == 8'hFF) && (b_q[22:0] != 23'd0);

    always_ff @(posedge clk) begin
        if (!rstn) v1 <= 1'b0;
        else       v1 <= issue;
        if (issue) begin
            idx_s1  <= index;
            last_s1 <= (index == IW'(WIDTH - 1));
            sign_s1 <= op_a[31] ^ b_q[31];
            exp_s1  <= 10'({2'b00, op_a[30:23]}) + 10'({2'b00, b_q[30:23]}) - 10'sd127;
            nan_s1  <= a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
            inf_s1  <= a_inf | b_inf;
            zero_s1 <= a_zero | b_zero;
`ifdef SINGLE_MULT_ROUND_EN
            prod_s1 <= 48'({1'b1, op_a[22:0]}) * 48'({1'b1, b_q[22:0]});
`else
            prod_s1 <= 25'((48'({1'b1, op_a[22:0]}) * 48'({1'b1, b_q[22:0]})) >> 23);
`endif
        end
    end

    // ------------------------------------ stage 2: normalise, round, pack
    logic signed [9:0] norm_exp, exp_r;
    logic [22:0]       mant;
    logic [23:0]       mant_r;
    logic              rnd_up;
    logic [31:0]       result;
`ifdef SINGLE_MULT_ROUND_EN
    logic              guard, sticky;
`endif

    always_comb begin
        // The product of two 1.x mantissas lies in [1,4). Bit 47 set means >= 2.
        norm_exp = prod_s1[47] ? exp_s1 + 10'sd1 : exp_s1;
        mant     = prod_s1[47] ? prod_s1[46:24] : prod_s1[45:23];
`ifdef SINGLE_MULT_ROUND_EN
        guard    = prod_s1[47] ? prod_s1[23] : prod_s1[22];
        sticky   = prod_s1[47] ? (|prod_s1[22:0]) : (|prod_s1[21:0]);
        rnd_up   = guard & (sticky | mant[0]);
`else
        rnd_up   = 1'b0;
`endif
        mant_r   = {1'b0, mant} + {23'd0, rnd_up};
        // A carry out of the mantissa leaves the fraction field at zero and bumps the exponent.
        exp_r    = norm_exp + 10'(mant_r[23]);

        if (nan_s1)                   result = 32'h7FC00000;
        else if (inf_s1)              result = {sign_s1, 8'hFF, 23'd0};
        else if (zero_s1)             result = {sign_s1, 31'd0};
        else if (norm_exp <= 10'sd0)  result = {sign_s1, 31'd0};
        else if (exp_r >= 10'sd255)   result = {sign_s1, 8'hFF, 23'd0};
        else                          result = {sign_s1, exp_r[7:0], mant_r[22:0]};
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            v2      <= 1'b0;
            last_s2 <= 1'b0;
            for (int i = 0; i < WIDTH; i++) vector_c[i] <= '0;
        end else begin
            v2      <= v1;
            last_s2 <= v1 & last_s1;
            if (v1) vector_c[idx_s1] <= result;
        end
    end

endmodule
